xbar_bank_port_ctrl: RTL

//  Slave-side port controller for one TCDM bank of the HWCE crossbar, directly downstream of the
//  per-bank master selector. Consumes its (sel, en_out) pair, steers the chosen master's request

---
 rtl/xbar_hwce_pkg.sv | 16 +
 rtl/xbar_resp_tag_pipe.sv | 36 +++
 rtl/xbar_bank_port_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/xbar_hwce_pkg.sv
// rtl/xbar_hwce_pkg.sv - shared types and constants for the HWCE crossbar bank port
// Purpose: response tag type carried through the bank latency pipe, stall counter width.
// Ports: none (package).
package xbar_hwce_pkg;

  localparam int NUM_INPUT_DEF = 3;
  localparam int TAG_ID_W      = (NUM_INPUT_DEF > 1) ? $clog2(NUM_INPUT_DEF) : 1;
  localparam int STALL_CNT_W   = 16;

  // One in-flight transaction: valid plus the index of the master it returns to.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } resp_tag_t;

endpackage

// File: rtl/xbar_resp_tag_pipe.sv
// rtl/xbar_resp_tag_pipe.sv - fixed-depth shift pipe of response tags
// Purpose: delays each accepted-request tag by DEPTH cycles to line it up with bank read data.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears every stage)
//   tag_i     tag entering stage 0 this cycle
//   tag_o     tag leaving the last stage
module xbar_resp_tag_pipe
  import xbar_hwce_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  resp_tag_t tag_i,
  output resp_tag_t tag_o
);

  resp_tag_t stage_q [DEPTH];

  // Shifts unconditionally: the bank never back-pressures its read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/xbar_bank_port_ctrl.sv
// rtl/xbar_bank_port_ctrl.sv - slave-side port controller for one TCDM bank
// Purpose: steers the master chosen by the per-bank selector onto the bank, returns its grant,
//   and routes the bank response back to that master RESP_LATENCY cycles after acceptance.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sel_i, en_i       selector index and hit flag
//   data_*_i          per-master request (address, wen 1=read, wdata, byte enables)
//   data_gnt_o        per-master grant (at most one bit set)
//   data_r_valid_o    per-master response valid, one cycle per accepted request
//   data_r_rdata_o    bank read data broadcast to every master
//   bank_*            bank request/address/wen/wdata/be, grant and read data
//   stall_cnt_o       saturating count of cycles the bank refused a request
//   sel_err_o         sticky flag: selector hit with an out-of-range index
module xbar_bank_port_ctrl
  import xbar_hwce_pkg::*;
#(
  parameter int NUM_INPUT     = 3,
  parameter int SEL_WIDTH     = $clog2(NUM_INPUT),
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BE_WIDTH      = DATA_WIDTH/8,
  parameter int BANK_ADDR_LSB = 2,
  parameter int BANK_AW       = 12,
  parameter int RESP_LATENCY  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEL_WIDTH-1:0]   sel_i,
  input  logic                   en_i,
  input  logic [ADDR_WIDTH-1:0]  data_add_i     [NUM_INPUT],
  input  logic [NUM_INPUT-1:0]   data_wen_i,
  input  logic [DATA_WIDTH-1:0]  data_wdata_i   [NUM_INPUT],
  input  logic [BE_WIDTH-1:0]    data_be_i      [NUM_INPUT],
  output logic [NUM_INPUT-1:0]   data_gnt_o,
  output logic [NUM_INPUT-1:0]   data_r_valid_o,
  output logic [DATA_WIDTH-1:0]  data_r_rdata_o [NUM_INPUT],
  output logic                   bank_req_o,
  output logic [BANK_AW-1:0]     bank_add_o,
  output logic                   bank_wen_o,
  output logic [DATA_WIDTH-1:0]  bank_wdata_o,
  output logic [BE_WIDTH-1:0]    bank_be_o,
  input  logic                   bank_gnt_i,
  input  logic [DATA_WIDTH-1:0]  bank_r_rdata_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output logic                   sel_err_o
);

  logic      sel_in_range;
  logic      sel_ok;
  logic      accept;
  logic      unused_addr_bits;
  resp_tag_t tag_in;
  resp_tag_t tag_out;

  assign sel_in_range = (int'(sel_i) < NUM_INPUT);
  assign sel_ok       = en_i && sel_in_range;
  assign bank_req_o   = sel_ok;
  assign accept       = sel_ok && bank_gnt_i;

  // Request mux written as a compare loop so an out-of-range sel_i never indexes the arrays.
  always_comb begin
    bank_add_o   = '0;
    bank_wen_o   = 1'b1;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    data_gnt_o   = '0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      if (sel_ok && (sel_i == SEL_WIDTH'(k))) begin
        bank_add_o    = data_add_i[k][BANK_ADDR_LSB +: BANK_AW];
        bank_wen_o    = data_wen_i[k];
        bank_wdata_o  = data_wdata_i[k];
        bank_be_o     = data_be_i[k];
        data_gnt_o[k] = bank_gnt_i;
      end
    end
  end

  // Only the word-address field reaches the bank; the rest of each address is ignored.
  always_comb begin
    unused_addr_bits = 1'b0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      unused_addr_bits = unused_addr_bits ^ (^data_add_i[k]);
    end
  end

  always_comb begin
    tag_in.valid = accept;
    tag_in.id    = accept ? TAG_ID_W'(sel_i) : '0;
  end

  xbar_resp_tag_pipe #(
    .DEPTH (RESP_LATENCY)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // Read data is broadcast; only the addressed master sees valid.
  always_comb begin
    for (int k = 0; k < NUM_INPUT; k++) begin
      data_r_valid_o[k] = tag_out.valid && (tag_out.id == TAG_ID_W'(k));
      data_r_rdata_o[k] = bank_r_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      sel_err_o   <= 1'b0;
    end else begin
      if (bank_req_o && !bank_gnt_i && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (en_i && !sel_in_range) begin
        sel_err_o <= 1'b1;
      end
    end
  end

endmodule
